// File: rtl/pc_gen_unit_pkg.sv
// ============================================================================
// pc_gen_unit_pkg : shared state encodings and default sizing for the PC generator
// Revision: 1.0
// ============================================================================
`default_nettype none

package pc_gen_unit_pkg;

    localparam int          DEFAULT_XLEN      = 32;
    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

    typedef enum logic [0:0] {
        PCG_WARM = 1'b0,
        PCG_RUN  = 1'b1
    } pcg_state_e;

endpackage

`default_nettype wire

// File: rtl/pc_redirect_buf.sv
// ============================================================================
// pc_redirect_buf : 1-deep pending redirect target; set overwrites, set beats clear
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_redirect_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_i,
    input  logic            clr_i,
    input  logic [XLEN-1:0] tgt_i,
    output logic            valid_o,
    output logic [XLEN-1:0] tgt_o
);

    logic            valid_q;
    logic [XLEN-1:0] tgt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tgt_q   <= '0;
        end else if (set_i) begin
            valid_q <= 1'b1;
            tgt_q   <= tgt_i;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign tgt_o   = tgt_q;

endmodule

`default_nettype wire

// File: rtl/pc_gen_unit.sv
// ============================================================================
// pc_gen_unit : fetch-stage PC register and next-PC selection with warm-up,
// stalls and buffered redirects. Optional PC_ALIGN_CHECK_EN adds misalign_o.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_gen_unit
    import pc_gen_unit_pkg::*;
#(
    parameter int              XLEN          = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_VEC     = DEFAULT_RESET_VEC,
    parameter int              WARMUP_CYCLES = 1,
    parameter int              INST_BYTES    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_stall,
    input  logic            ifid_stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] next_pc,
    output logic            pc_have_inst,
    output logic            redirect_pending
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic            misalign_o
`endif
);

    localparam logic [XLEN-1:0] INST_STEP  = XLEN'(INST_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INST_BYTES - 1));
    localparam logic [3:0]      WARMUP_LIM = 4'(WARMUP_CYCLES);

    pcg_state_e      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            have_q, have_d;

    logic            w_buf_set;
    logic            w_buf_clr;
    logic            w_pend_valid;
    logic [XLEN-1:0] w_pend_tgt;
    logic [XLEN-1:0] w_live_tgt;
    logic            w_take;
    logic [XLEN-1:0] w_take_tgt;

`ifdef PC_ALIGN_CHECK_EN
    localparam int ALIGN_BITS = $clog2(INST_BYTES);
    logic misalign_q, misalign_d;
    assign w_live_tgt = redirect_pc;
`else
    // Without the checker, odd low bits are simply dropped on the way in.
    assign w_live_tgt = redirect_pc & ALIGN_MASK;
`endif

    pc_redirect_buf #(
        .XLEN (XLEN)
    ) u_redirect_buf (
        .clk     (clk),
        .rst     (rst),
        .set_i   (w_buf_set),
        .clr_i   (w_buf_clr),
        .tgt_i   (w_live_tgt),
        .valid_o (w_pend_valid),
        .tgt_o   (w_pend_tgt)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        have_d     = have_q;
        w_buf_set  = 1'b0;
        w_buf_clr  = 1'b0;
        w_take     = 1'b0;
        w_take_tgt = w_live_tgt;
`ifdef PC_ALIGN_CHECK_EN
        misalign_d = 1'b0;
`endif

        case (state_q)
            PCG_WARM: begin
                if (cnt_q == WARMUP_LIM) begin
                    state_d   = PCG_RUN;
                    have_d    = 1'b1;
                    w_buf_clr = 1'b1;
                    if (redirect_valid) begin
                        w_take     = 1'b1;
                        w_take_tgt = w_live_tgt;
                    end else if (w_pend_valid) begin
                        w_take     = 1'b1;
                        w_take_tgt = w_pend_tgt;
                    end
                end else begin
                    cnt_d     = cnt_q + 4'd1;
                    w_buf_set = redirect_valid;
                end
            end
            default: begin
                if (pc_stall) begin
                    have_d    = 1'b0;
                    w_buf_set = redirect_valid;
                end else if (ifid_stall) begin
                    w_buf_set = redirect_valid;
                end else if (redirect_valid) begin
                    w_take     = 1'b1;
                    w_take_tgt = w_live_tgt;
                end else if (w_pend_valid) begin
                    w_take     = 1'b1;
                    w_take_tgt = w_pend_tgt;
                end else begin
                    pc_d   = pc_q + INST_STEP;
                    have_d = 1'b1;
                end
            end
        endcase

        if (w_take) begin
            pc_d      = w_take_tgt;
            have_d    = 1'b1;
            w_buf_clr = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
            if (|w_take_tgt[ALIGN_BITS-1:0]) begin
                have_d     = 1'b0;
                misalign_d = 1'b1;
            end
`endif
        end

        if (rst) begin
            state_d = PCG_WARM;
            cnt_d   = 4'd0;
            pc_d    = RESET_VEC;
            have_d  = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            misalign_d = 1'b0;
`endif
        end
    end

    // rst is already folded into the _d values above.
    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pc_q    <= pc_d;
        have_q  <= have_d;
`ifdef PC_ALIGN_CHECK_EN
        misalign_q <= misalign_d;
`endif
    end

    assign pc               = pc_q;
    assign next_pc          = pc_d;
    assign pc_have_inst     = have_q;
    assign redirect_pending = w_pend_valid;
`ifdef PC_ALIGN_CHECK_EN
    assign misalign_o       = misalign_q;
`endif

endmodule

`default_nettype wire
